debug_regbank_serializer: RTL and testbench

- Debug-path stage directly downstream of the register bank's five debug read ports (registers 0..4).
- On a dump request it snapshots all five words, then streams them as bytes to the debug UART transmitter over a valid/ready handshake.
- The stream is a header byte followed by the register bytes.
- The block sits between the register bank and the UART TX in the debug unit.

---
 rtl/debug_regbank_serializer.sv | 174 +++++++++++++++++
 tb/tb_debug_regbank_serializer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_regbank_serializer.sv
// Debug register-bank dump serializer.
// Snapshots debug words 0..4 on request and streams a header byte followed by
// every register byte (MSB first) to the debug UART over a valid/ready handshake.
module debug_regbank_serializer #(
    parameter int          word_wide   = 32,
    parameter logic [7:0]  header_byte = 8'hA5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dumpReq,
    input  logic [word_wide-1:0] regData0,
    input  logic [word_wide-1:0] regData1,
    input  logic [word_wide-1:0] regData2,
    input  logic [word_wide-1:0] regData3,
    input  logic [word_wide-1:0] regData4,
    input  logic                 txReady,
    output logic                 txValid,
    output logic [7:0]           txData,
    output logic                 busy,
    output logic                 done
);

    localparam int NBYTES = word_wide / 8;
    localparam int BIDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    // Byte-select table is padded to a power of two so any index value is in range.
    localparam int NSLOTS = 1 << BIDX_W;
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(NBYTES - 1);
    localparam logic [2:0]        LAST_REG  = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_DATA   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [word_wide-1:0] r_snap [5];
    logic [2:0]           r_reg_idx;
    logic [BIDX_W-1:0]    r_byte_idx;

    logic [word_wide-1:0] w_reg_in [5];
    logic [word_wide-1:0] w_cur_word;
    logic [7:0]           w_bytes [NSLOTS];
    logic                 w_accept;
    logic                 w_last;

    assign w_reg_in[0] = regData0;
    assign w_reg_in[1] = regData1;
    assign w_reg_in[2] = regData2;
    assign w_reg_in[3] = regData3;
    assign w_reg_in[4] = regData4;

    // txValid is decoded from registered state only, so acceptance never
    // depends combinationally on txReady.
    assign w_accept = txValid && txReady;
    assign w_last   = (r_reg_idx == LAST_REG) && (r_byte_idx == LAST_BYTE);

    // Select the snapshot word currently being streamed.
    always_comb begin
        w_cur_word = '0;
        case (r_reg_idx)
            3'd0:    w_cur_word = r_snap[0];
            3'd1:    w_cur_word = r_snap[1];
            3'd2:    w_cur_word = r_snap[2];
            3'd3:    w_cur_word = r_snap[3];
            3'd4:    w_cur_word = r_snap[4];
            default: w_cur_word = '0;
        endcase
    end

    // Byte 0 is the most significant byte of the word.
    generate
        for (genvar gi = 0; gi < NSLOTS; gi++) begin : g_byte_sel
            if (gi < NBYTES) begin : g_real
                assign w_bytes[gi] = w_cur_word[word_wide-1-8*gi -: 8];
            end else begin : g_pad
                assign w_bytes[gi] = 8'h00;
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (dumpReq)            w_state_next = S_HEADER;
            S_HEADER: if (w_accept)           w_state_next = S_DATA;
            S_DATA:   if (w_accept && w_last) w_state_next = S_DONE;
            S_DONE:                           w_state_next = S_IDLE;
            default:                          w_state_next = S_IDLE;
        endcase
    end

    // Output decode from registered state, counters and snapshot.
    always_comb begin
        txValid = 1'b0;
        txData  = 8'h00;
        busy    = 1'b0;
        done    = 1'b0;
        case (r_state)
            S_HEADER: begin
                txValid = 1'b1;
                txData  = header_byte;
                busy    = 1'b1;
            end
            S_DATA: begin
                txValid = 1'b1;
                txData  = w_bytes[r_byte_idx];
                busy    = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Snapshot capture and register/byte counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                r_snap[i] <= '0;
            end
            r_reg_idx  <= '0;
            r_byte_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (dumpReq) begin
                        for (int i = 0; i < 5; i++) begin
                            r_snap[i] <= w_reg_in[i];
                        end
                        r_reg_idx  <= '0;
                        r_byte_idx <= '0;
                    end
                end
                S_HEADER: begin
                    if (w_accept) begin
                        r_reg_idx  <= '0;
                        r_byte_idx <= '0;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        if (w_last) begin
                            // Frame complete: park counters so regIdx never passes 4.
                            r_reg_idx  <= '0;
                            r_byte_idx <= '0;
                        end else if (r_byte_idx == LAST_BYTE) begin
                            r_byte_idx <= '0;
                            r_reg_idx  <= r_reg_idx + 3'd1;
                        end else begin
                            r_byte_idx <= r_byte_idx + BIDX_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_regbank_serializer.sv
// Directed bench for debug_regbank_serializer (default parameters).
// Outputs are observed and txReady is driven on the falling clock edge.
module tb_debug_regbank_serializer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dumpReq = 1'b0;
    logic [31:0] regData0 = '0;
    logic [31:0] regData1 = '0;
    logic [31:0] regData2 = '0;
    logic [31:0] regData3 = '0;
    logic [31:0] regData4 = '0;
    logic        txReady = 1'b0;
    logic        txValid;
    logic [7:0]  txData;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    // Capture state
    logic [7:0] byte_q [$];
    int         xfer_q [$];
    int         done_q [$];
    int         cyc;
    int         stall_err;
    bit         prev_stall;
    logic [7:0] prev_data;

    logic [7:0] exp_frame [21] = '{
        8'hA5,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h11, 8'h22, 8'h33, 8'h44,
        8'hDE, 8'hAD, 8'hBE, 8'hEF,
        8'h00, 8'h00, 8'h00, 8'h01,
        8'hFF, 8'hFF, 8'hFF, 8'hFF
    };
    logic [15:0] bp_pat = 16'b0100_1110_0101_1001;

    debug_regbank_serializer #(
        .word_wide   (32),
        .header_byte (8'hA5)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .dumpReq  (dumpReq),
        .regData0 (regData0),
        .regData1 (regData1),
        .regData2 (regData2),
        .regData3 (regData3),
        .regData4 (regData4),
        .txReady  (txReady),
        .txValid  (txValid),
        .txData   (txData),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    task automatic clear_capture();
        byte_q.delete();
        xfer_q.delete();
        done_q.delete();
        cyc        = 0;
        stall_err  = 0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
    endtask

    // One observation cycle at a falling edge: record transfers, done pulses
    // and handshake stability, drive txReady for the coming rising edge.
    task automatic step(input bit rdy);
        txReady = rdy;
        cyc++;
        if (prev_stall && !(txValid === 1'b1 && txData === prev_data)) begin
            stall_err++;
        end
        if (txValid === 1'b1 && rdy) begin
            byte_q.push_back(txData);
            xfer_q.push_back(cyc);
            $display("cyc %0d: byte %0d = %02h", cyc, byte_q.size() - 1, txData);
        end
        if (done === 1'b1) begin
            done_q.push_back(cyc);
            $display("cyc %0d: done pulse", cyc);
        end
        prev_stall = (txValid === 1'b1) && !rdy;
        prev_data  = txData;
        @(negedge clock);
    endtask

    task automatic load_default_regs();
        regData0 = 32'h00000000;
        regData1 = 32'h11223344;
        regData2 = 32'hDEADBEEF;
        regData3 = 32'h00000001;
        regData4 = 32'hFFFFFFFF;
    endtask

    task automatic start_dump();
        dumpReq = 1'b1;
        @(negedge clock);
        dumpReq = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (txValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || txData !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: valid=%b busy=%b done=%b data=%02h required 0/0/0/00",
                     txValid, busy, done, txData);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (txValid !== 1'b0 || busy !== 1'b0 || txData !== 8'h00) begin
            errors++;
            $display("FAIL idle_after_reset: valid=%b busy=%b data=%02h required 0/0/00",
                     txValid, busy, txData);
        end
        load_default_regs();
        txReady = 1'b0;
        start_dump();
        checks++;
        if (txValid !== 1'b1 || txData !== 8'hA5 || busy !== 1'b1) begin
            errors++;
            $display("FAIL header_state: valid=%b data=%02h busy=%b required 1/a5/1",
                     txValid, txData, busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (txValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || txData !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b done=%b data=%02h required 0/0/0/00",
                     txValid, busy, done, txData);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        load_default_regs();
        clear_capture();
        start_dump();
        for (int k = 0; k < 26; k++) step(1'b1);
        checks++;
        if (byte_q.size() != 21) begin
            errors++;
            $display("FAIL basic_len: got %0d bytes required 21", byte_q.size());
        end
        for (int i = 0; i < 21 && i < byte_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_frame[i]) begin
                errors++;
                $display("FAIL basic_byte%0d: got %02h required %02h", i, byte_q[i], exp_frame[i]);
            end
        end
        checks++;
        if (xfer_q.size() < 1 || xfer_q[0] != 1) begin
            errors++;
            $display("FAIL basic_header_cycle: got %0d required 1",
                     (xfer_q.size() > 0) ? xfer_q[0] : -1);
        end
        checks++;
        if (done_q.size() != 1 || done_q[0] != 22) begin
            errors++;
            $display("FAIL basic_done: pulses=%0d first=%0d required 1 at 22",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
        checks++;
        if (busy !== 1'b0 || txValid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b valid=%b required 0/0", busy, txValid);
        end
    endtask

    task automatic test_backpressure();
        load_default_regs();
        clear_capture();
        start_dump();
        for (int k = 0; k < 100; k++) step(bp_pat[k % 16]);
        checks++;
        if (byte_q.size() != 21) begin
            errors++;
            $display("FAIL bp_len: got %0d bytes required 21", byte_q.size());
        end
        for (int i = 0; i < 21 && i < byte_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_frame[i]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %02h required %02h", i, byte_q[i], exp_frame[i]);
            end
        end
        checks++;
        if (stall_err != 0) begin
            errors++;
            $display("FAIL bp_stall: got %0d unstable stall cycles required 0", stall_err);
        end
        checks++;
        if (done_q.size() != 1) begin
            errors++;
            $display("FAIL bp_done: got %0d pulses required 1", done_q.size());
        end
    endtask

    task automatic test_snapshot();
        load_default_regs();
        clear_capture();
        start_dump();
        step(1'b1);
        regData2 = 32'h12345678;
        for (int k = 0; k < 25; k++) step(1'b1);
        checks++;
        if (byte_q.size() != 21) begin
            errors++;
            $display("FAIL snap_len: got %0d bytes required 21", byte_q.size());
        end
        for (int i = 9; i < 13 && i < byte_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_frame[i]) begin
                errors++;
                $display("FAIL snap_byte%0d: got %02h required %02h", i, byte_q[i], exp_frame[i]);
            end
        end
        load_default_regs();
    endtask

    task automatic test_request_during_busy();
        load_default_regs();
        clear_capture();
        start_dump();
        for (int k = 0; k < 40; k++) begin
            dumpReq = (k == 7);
            step(1'b1);
        end
        dumpReq = 1'b0;
        checks++;
        if (byte_q.size() != 21) begin
            errors++;
            $display("FAIL busyreq_len: got %0d bytes required 21", byte_q.size());
        end
        checks++;
        if (done_q.size() != 1) begin
            errors++;
            $display("FAIL busyreq_done: got %0d pulses required 1", done_q.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busyreq_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_back_to_back();
        load_default_regs();
        clear_capture();
        dumpReq = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 60; k++) begin
            dumpReq = (k < 30);
            step(1'b1);
        end
        dumpReq = 1'b0;
        checks++;
        if (byte_q.size() != 42) begin
            errors++;
            $display("FAIL b2b_len: got %0d bytes required 42", byte_q.size());
        end
        for (int i = 0; i < 42 && i < byte_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_frame[i % 21]) begin
                errors++;
                $display("FAIL b2b_byte%0d: got %02h required %02h", i, byte_q[i], exp_frame[i % 21]);
            end
        end
        checks++;
        if (xfer_q.size() < 22 || xfer_q[21] != 24) begin
            errors++;
            $display("FAIL b2b_second_header: cycle %0d required 24",
                     (xfer_q.size() > 21) ? xfer_q[21] : -1);
        end
        checks++;
        if (done_q.size() != 2 || done_q[0] != 22 || done_q[1] != 45) begin
            errors++;
            $display("FAIL b2b_done: pulses=%0d required 2 at 22 and 45", done_q.size());
        end
    endtask

    task automatic test_reset_mid();
        load_default_regs();
        clear_capture();
        start_dump();
        for (int k = 0; k < 10; k++) step(1'b1);
        checks++;
        if (byte_q.size() != 10 || txValid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: bytes=%0d valid=%b required 10/1", byte_q.size(), txValid);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (txValid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || txData !== 8'h00) begin
            errors++;
            $display("FAIL rstmid_async: valid=%b busy=%b done=%b data=%02h required 0/0/0/00",
                     txValid, busy, done, txData);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        clear_capture();
        for (int k = 0; k < 30; k++) step(1'b1);
        checks++;
        if (byte_q.size() != 0 || done_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_quiet: bytes=%0d done=%0d required 0/0", byte_q.size(), done_q.size());
        end
        clear_capture();
        start_dump();
        for (int k = 0; k < 26; k++) step(1'b1);
        checks++;
        if (byte_q.size() != 21 || done_q.size() != 1) begin
            errors++;
            $display("FAIL rstmid_new_frame: bytes=%0d done=%0d required 21/1", byte_q.size(), done_q.size());
        end
        for (int i = 0; i < 21 && i < byte_q.size(); i++) begin
            checks++;
            if (byte_q[i] !== exp_frame[i]) begin
                errors++;
                $display("FAIL rstmid_byte%0d: got %02h required %02h", i, byte_q[i], exp_frame[i]);
            end
        end
    endtask

    initial begin
        clear_capture();
        @(negedge clock);
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_request_during_busy();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
